// File: rtl/tty_pkg.sv
// Shared tty constants: character width, FIFO depth and the "no character" code
// returned by bus reads when nothing is queued.
package tty_pkg;

    localparam int TTY_CHAR_W     = 8;
    localparam int TTY_FIFO_DEPTH = 16;

    typedef logic [TTY_CHAR_W-1:0] tty_char_t;

    localparam tty_char_t TTY_NO_CHAR = 8'hFF;

endpackage

// File: rtl/tty_fifo_mem.sv
// Character storage for the tty input FIFO: two write ports, one asynchronous read port.
// Port 1 is written last, so it wins if both ports ever target the same address.
module tty_fifo_mem
    import tty_pkg::*;
#(
    parameter int DEPTH  = TTY_FIFO_DEPTH,
    parameter int ADDR_W = 4
)
(
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_wa0,
    input  tty_char_t         i_wd0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_wa1,
    input  tty_char_t         i_wd1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_ra,
    output tty_char_t         o_rd
);

    tty_char_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we0) begin
            r_mem[i_wa0] <= i_wd0;
        end
        if (i_we1) begin
            r_mem[i_wa1] <= i_wd1;
        end
    end

    assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/tty_char_fifo.sv
// Merges keyboard and UART characters into one in-order queue and pops one character
// per rising edge of the CPU read strobe; reads while empty return TTY_NO_CHAR.
module tty_char_fifo
    import tty_pkg::*;
#(
    parameter int DEPTH = TTY_FIFO_DEPTH,
    parameter int PTR_W = 4
)
(
    input  logic             i_clk_50mhz,
    input  logic             i_rst_n,
    input  logic             i_kb_valid,
    input  tty_char_t        i_kb_data,
    input  logic             i_rx_valid,
    input  tty_char_t        i_rx_data,
    input  logic             i_rd,
    output tty_char_t        o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [PTR_W:0]   o_count,
    output logic             o_overflow,
    input  logic             i_clr_ovf
);

    localparam logic [PTR_W+1:0] L_DEPTH = (PTR_W+2)'(DEPTH);

    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W:0]   r_count;
    tty_char_t        r_rdData;
    logic             r_overflow;
    logic             r_rdQ;

    logic             w_rdRise;
    logic             w_pop;
    logic [PTR_W+1:0] w_free;
    logic             w_kbAcc;
    logic             w_rxAcc;
    logic             w_drop;
    logic [PTR_W-1:0] w_wa0;
    logic [PTR_W-1:0] w_wa1;
    tty_char_t        w_memRdData;

    assign w_rdRise = i_rd & ~r_rdQ;
    assign w_pop    = w_rdRise & (r_count != '0);

    // A pop frees its slot in the same cycle, so a full queue can still take one push.
    assign w_free  = L_DEPTH - {1'b0, r_count} + {{(PTR_W+1){1'b0}}, w_pop};
    assign w_kbAcc = i_kb_valid & (w_free != '0);
    assign w_rxAcc = i_rx_valid & (w_kbAcc ? (w_free > (PTR_W+2)'(1)) : (w_free != '0));
    assign w_drop  = (i_kb_valid & ~w_kbAcc) | (i_rx_valid & ~w_rxAcc);

    assign w_wa0 = r_wrPtr;
    assign w_wa1 = w_kbAcc ? r_wrPtr + PTR_W'(1) : r_wrPtr;

    tty_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .i_clk (i_clk_50mhz),
        .i_wa0 (w_wa0),
        .i_wd0 (i_kb_data),
        .i_we0 (w_kbAcc),
        .i_wa1 (w_wa1),
        .i_wd1 (i_rx_data),
        .i_we1 (w_rxAcc),
        .i_ra  (r_rdPtr),
        .o_rd  (w_memRdData)
    );

    always_ff @(posedge i_clk_50mhz) begin
        if (!i_rst_n) begin
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_rdData   <= TTY_NO_CHAR;
            r_overflow <= 1'b0;
            r_rdQ      <= 1'b0;
        end else begin
            r_rdQ <= i_rd;
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_wrPtr <= r_wrPtr + PTR_W'(w_kbAcc) + PTR_W'(w_rxAcc);
            r_count <= r_count + (PTR_W+1)'(w_kbAcc) + (PTR_W+1)'(w_rxAcc) - (PTR_W+1)'(w_pop);
            if (w_rdRise) begin
                r_rdData <= w_pop ? w_memRdData : TTY_NO_CHAR;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_rd_data  = r_rdData;
    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_tty_char_fifo.sv
// Self-checking bench for tty_char_fifo: a queue model acts as scoreboard for popped
// characters, a vector table covers basic traffic, hand sequences cover full/wrap/hold cases.
module tb_tty_char_fifo;
    import tty_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rstN;
    logic       kbValid;
    logic [7:0] kbData;
    logic       rxValid;
    logic [7:0] rxData;
    logic       rd;
    logic       clrOvf;
    logic [7:0] rdData;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] mQ[$];
    logic [7:0] mRdData;
    bit         mOvf;
    bit         mPrevRd;

    typedef struct {
        string      name;
        bit         kbv;
        logic [7:0] kbd;
        bit         rxv;
        logic [7:0] rxd;
        bit         r;
        bit         clr;
        int         expCount;
        bit         expOvf;
        logic [7:0] expRd;
    } vec_t;

    vec_t vecs[14];

    tty_char_fifo dut (
        .i_clk_50mhz (clk),
        .i_rst_n     (rstN),
        .i_kb_valid  (kbValid),
        .i_kb_data   (kbData),
        .i_rx_valid  (rxValid),
        .i_rx_data   (rxData),
        .i_rd        (rd),
        .o_rd_data   (rdData),
        .o_empty     (empty),
        .o_full      (full),
        .o_count     (count),
        .o_overflow  (overflow),
        .i_clr_ovf   (clrOvf)
    );

    always #10 clk = ~clk;

    // Both storage write ports active must never target the same slot.
    always @(negedge clk) begin
        if (rstN === 1'b1 && dut.w_kbAcc === 1'b1 && dut.w_rxAcc === 1'b1) begin
            assertCount++;
            if (dut.w_wa0 === dut.w_wa1) begin
                failCount++;
                $display("[TB] FAIL write-port clash: wa0 %0h wa1 %0h must differ", dut.w_wa0, dut.w_wa1);
            end
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit kbv, input logic [7:0] kbd, input bit rxv,
                                 input logic [7:0] rxd, input bit r, input bit clr);
        int free;
        bit rise, pop, kbA, rxA;
        kbValid = kbv;
        kbData  = kbd;
        rxValid = rxv;
        rxData  = rxd;
        rd      = r;
        clrOvf  = clr;
        rise = r && !mPrevRd;
        pop  = rise && (mQ.size() > 0);
        free = DEPTH - mQ.size() + (pop ? 1 : 0);
        kbA  = kbv && (free >= 1);
        rxA  = rxv && (free >= 1 + (kbA ? 1 : 0));
        if (pop) mRdData = mQ.pop_front();
        else if (rise) mRdData = 8'hFF;
        if (kbA) mQ.push_back(kbd);
        if (rxA) mQ.push_back(rxd);
        if ((kbv && !kbA) || (rxv && !rxA)) mOvf = 1'b1;
        else if (clr) mOvf = 1'b0;
        mPrevRd = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " rd_data"}, 32'(rdData), 32'(mRdData));
        checkVal({tag, " count"}, 32'(count), 32'(mQ.size()));
        checkVal({tag, " empty"}, 32'(empty), 32'(mQ.size() == 0));
        checkVal({tag, " full"}, 32'(full), 32'(mQ.size() == DEPTH));
        checkVal({tag, " overflow"}, 32'(overflow), 32'(mOvf));
    endtask

    task automatic doReset();
        rstN    = 1'b0;
        kbValid = 1'b0;
        rxValid = 1'b0;
        rd      = 1'b0;
        clrOvf  = 1'b0;
        kbData  = 8'h00;
        rxData  = 8'h00;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        mQ.delete();
        mRdData = 8'hFF;
        mOvf    = 1'b0;
        mPrevRd = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"rd empty",  0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'hFF};
        vecs[1]  = '{"idle0",     0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'hFF};
        vecs[2]  = '{"kb 41",     1, 8'h41, 0, 8'h00, 0, 0, 1, 0, 8'hFF};
        vecs[3]  = '{"idle1",     0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hFF};
        vecs[4]  = '{"rx 42",     0, 8'h00, 1, 8'h42, 0, 0, 2, 0, 8'hFF};
        vecs[5]  = '{"pop 41",    0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'h41};
        vecs[6]  = '{"idle2",     0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h41};
        vecs[7]  = '{"pop 42",    0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h42};
        vecs[8]  = '{"idle3",     0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h42};
        vecs[9]  = '{"kb61 rx62", 1, 8'h61, 1, 8'h62, 0, 0, 2, 0, 8'h42};
        vecs[10] = '{"pop 61",    0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'h61};
        vecs[11] = '{"idle4",     0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h61};
        vecs[12] = '{"pop 62",    0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h62};
        vecs[13] = '{"idle5",     0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h62};

        doReset();
        checkOutput("reset");
        checkVal("reset rd_data const", 32'(rdData), 32'h0000_00FF);
        checkVal("reset empty const", 32'(empty), 32'd1);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].kbv, vecs[i].kbd, vecs[i].rxv, vecs[i].rxd, vecs[i].r, vecs[i].clr);
            checkOutput(vecs[i].name);
            checkVal({vecs[i].name, " tbl count"}, 32'(count), 32'(vecs[i].expCount));
            checkVal({vecs[i].name, " tbl overflow"}, 32'(overflow), 32'(vecs[i].expOvf));
            checkVal({vecs[i].name, " tbl rd_data"}, 32'(rdData), 32'(vecs[i].expRd));
        end

        // Fill to 15, then a dual push where only the keyboard character fits.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 8'(8'h80 + i), 0, 8'h00, 0, 0);
        end
        checkOutput("fill15");
        checkVal("fill15 count", 32'(count), 32'd15);
        applyStimulus(1, 8'h31, 1, 8'h32, 0, 0);
        checkOutput("drop rx");
        checkVal("drop rx count", 32'(count), 32'd16);
        checkVal("drop rx full", 32'(full), 32'd1);
        checkVal("drop rx overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
            checkOutput("drain1");
            applyStimulus(0, 8'h00, 0, 8'h00, 0, 0);
        end
        checkVal("drain1 last rd_data", 32'(rdData), 32'h31);
        checkVal("drain1 empty", 32'(empty), 32'd1);

        // Full queue: pop and push in the same cycle are both accepted.
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1);
        checkVal("clr overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 8'(8'hA0 + i), 0, 8'h00, 0, 0);
        end
        checkVal("fill16 full", 32'(full), 32'd1);
        applyStimulus(1, 8'h7A, 0, 8'h00, 1, 0);
        checkOutput("pop+push full");
        checkVal("pop+push count", 32'(count), 32'd16);
        checkVal("pop+push overflow", 32'(overflow), 32'd0);
        checkVal("pop+push rd_data", 32'(rdData), 32'hA0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
            checkOutput("drain2");
            applyStimulus(0, 8'h00, 0, 8'h00, 0, 0);
        end
        checkVal("drain2 last rd_data", 32'(rdData), 32'h7A);

        // Held read strobe pops exactly once.
        applyStimulus(1, 8'h11, 0, 8'h00, 0, 0);
        applyStimulus(1, 8'h12, 0, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 1, 8'h13, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
            checkOutput("hold rd");
        end
        checkVal("hold rd count", 32'(count), 32'd2);
        checkVal("hold rd rd_data", 32'(rdData), 32'h11);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0);

        // Clear and drop in the same cycle: set wins.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, 8'h00, 1, 8'(8'hC0 + i), 0, 0);
        end
        checkVal("refill full", 32'(full), 32'd1);
        applyStimulus(1, 8'h55, 0, 8'h00, 0, 1);
        checkOutput("clr+drop");
        checkVal("clr+drop overflow", 32'(overflow), 32'd1);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1);
        checkVal("clr alone overflow", 32'(overflow), 32'd0);

        // Reset mid-stream discards everything.
        doReset();
        checkOutput("mid reset");
        checkVal("mid reset count", 32'(count), 32'd0);
        checkVal("mid reset rd_data", 32'(rdData), 32'h0000_00FF);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
        checkOutput("rd after reset");
        checkVal("rd after reset rd_data", 32'(rdData), 32'h0000_00FF);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/tty_char_fifo.md
Name: tty_char_fifo

Overview:
- Character input buffer sitting between the keyboard/UART receive paths and the CPU bus read port of the tty block.
- Merges ASCII characters from the PS/2 keyboard decoder (`kb_*`) and the UART receiver (`rx_*`) into one in-order queue.
- Pops one character per CPU read, so bytes are no longer lost when the CPU does not read during the single-cycle key-release window.
- Returns 8'hFF on reads while empty.

Parameters:
- DEPTH, 16: queue capacity in characters; power of two, minimum 4.
- PTR_W, 4: log2(DEPTH); pointer width. The count is PTR_W+1 bits.

Ports:
- clk_50mhz  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- kb_valid  in  1  one-cycle pulse: new keyboard character on kb_data.
- kb_data  in  8  keyboard ASCII code.
- rx_valid  in  1  one-cycle pulse: new UART character on rx_data.
- rx_data  in  8  UART received byte.
- rd  in  1  CPU read strobe (level, multi-cycle); one pop per rising edge.
- rd_data  out  8  registered character returned to the bus.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  PTR_W+1  characters currently stored.
- overflow  out  1  sticky; set when any incoming character is dropped.
- clr_ovf  in  1  one-cycle pulse; clears overflow.

Behaviour:
- Reset (rst_n low at a clock edge):
  - rd_ptr = wr_ptr = 0, count = 0.
  - rd_data = 8'hFF, empty = 1, full = 0, overflow = 0.
  - Internal rd_q (previous rd) = 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all queued characters.
- Read edge: rd_rise = rd & ~rd_q, where rd_q is rd registered every cycle. A held rd causes exactly one pop.
- Pop (rd_rise & ~empty):
  - rd_data <= mem[rd_ptr], rd_ptr++ (mod DEPTH).
  - rd_data is valid from the cycle after the rd rising edge and holds until the next pop.
- rd_rise while empty: rd_data <= 8'hFF; pointers and count unchanged; no error flag.
- Push, up to two per cycle:
  - Keyboard has priority; order within a cycle is kb then rx.
  - free = DEPTH - count + (pop this cycle ? 1 : 0). The pop frees its slot in the same cycle.
  - kb_valid accepted if free >= 1. rx_valid accepted if free >= 1 + (kb accepted ? 1 : 0).
  - An accepted kb is written at wr_ptr; an accepted rx is written at wr_ptr+1 if kb was also accepted, else at wr_ptr.
  - wr_ptr advances by the number of accepted pushes, wrapping mod DEPTH.
- Drops: a rejected character is discarded and overflow <= 1. Newest data is dropped; older queued data is never overwritten.
- count <= count + accepted_pushes - pop. empty and full are decoded from registered count, so they update in the cycle after the push or pop.
- Push latency: a character pushed at edge N is poppable by an rd_rise sampled at edge N+1 or later. Push-to-rd_data is 2 cycles minimum.
- Simultaneous pop, overflow set and clr_ovf: clr_ovf and a new drop in the same cycle leave overflow = 1 (set wins).
- Full with pop and one push in the same cycle: both are accepted and count stays at DEPTH.
- No combinational path from any input to any output.

Decomposition:
- Shared package tty_pkg holds:
  - TTY_NO_CHAR = 8'hFF.
  - TTY_FIFO_DEPTH = 16.
  - TTY_CHAR_W = 8.
  The existing tty bus-read logic uses the same TTY_NO_CHAR constant.
- One sub-module, tty_fifo_mem: DEPTH x 8 register array with two write ports (wa0/wd0/we0, wa1/wd1/we1) and one asynchronous read port. Port 1 has priority on an address clash; the clash cannot occur by construction, and the verifier asserts this.
- Pointer, count, arbitration and the read-edge detector stay in tty_char_fifo.

Test Plan:
1. Reset, then pulse rd once -> one cycle later rd_data = 8'hFF; empty = 1, count = 0, overflow = 0.
2. kb_valid with 8'h41, then rx_valid with 8'h42 two cycles later; then two separate rd pulses -> rd_data reads 8'h41 then 8'h42; count goes 1, 2, 1, 0.
3. Same-cycle kb_valid 8'h61 and rx_valid 8'h62 -> count = 2; pops return 8'h61 then 8'h62 (kb first).
4. Fill 15 entries, then same-cycle kb 8'h31 and rx 8'h32 -> count = 16, full = 1, overflow = 1; the 16th pop returns 8'h31 and 8'h32 is never seen.
5. With full, rd rising edge in the same cycle as kb_valid 8'h7A -> count stays 16, overflow stays 0; 8'h7A is read last after 16 pops; pointers wrap correctly.
6. Hold rd high for 10 cycles with 3 entries stored -> exactly one pop (count 3 -> 2). clr_ovf in the same cycle as a drop -> overflow remains 1. rst_n low mid-stream -> count = 0 and rd_data = 8'hFF next cycle.
